// File: rtl/fact_seq_pkg.sv
// Shared definitions for the factorial sequencer and the SoC address decoder:
// FSM encoding, accelerator register map and status bit positions.
package fact_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_N   = 3'd1,
    S_WR_GO  = 3'd2,
    S_WAIT   = 3'd3,
    S_POLL   = 3'd4,
    S_RD_RES = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  localparam logic [1:0] ADDR_N    = 2'd0;
  localparam logic [1:0] ADDR_GO   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_RES  = 2'd3;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fact_seq_poll_timer.sv
// Saturating poll counter; clear wins over inc, and last flags that the
// current poll is the LIMIT-th one.
module poll_timer
  import fact_seq_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] MAX = W'(LIMIT);
  localparam logic [W-1:0] PEN = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt >= PEN);

endmodule

// File: rtl/fact_seq.sv
// Drives a memory-mapped factorial accelerator: writes n, writes go, polls
// status, reads the result. All outputs are registered from the next state.
module fact_seq
  import fact_seq_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  n_in,
  output logic [1:0]  a,
  output logic        we,
  output logic [3:0]  wd,
  input  logic [31:0] rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout,
  output logic [31:0] result
);

  state_t     state, state_nxt;
  logic [3:0] n_q, n_nxt;
  logic       fail, fail_nxt;
  logic       wait_cnt, wait_nxt;
  logic       to_set, poll_inc, poll_last;
  logic [1:0] a_nxt;
  logic       we_nxt, busy_nxt, done_nxt, err_nxt;
  logic [3:0] wd_nxt;

  // Cleared while leaving WR_GO, so the count starts at zero on WAIT entry.
  poll_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state == S_WR_GO),
    .inc   (poll_inc),
    .last  (poll_last)
  );

  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    fail_nxt  = fail;
    wait_nxt  = wait_cnt;
    to_set    = 1'b0;
    poll_inc  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_WR_N;
        n_nxt     = n_in;
        fail_nxt  = 1'b0;
      end
      S_WR_N:  state_nxt = S_WR_GO;
      S_WR_GO: begin
        state_nxt = S_WAIT;
        wait_nxt  = 1'b0;
      end
      S_WAIT: begin
        if (wait_cnt) state_nxt = S_POLL;
        wait_nxt = 1'b1;
      end
      S_POLL: begin
        // Error outranks done when both status bits are seen together.
        if (rd[STAT_ERR_BIT]) begin
          state_nxt = S_FIN;
          fail_nxt  = 1'b1;
        end else if (rd[STAT_DONE_BIT]) begin
          state_nxt = S_RD_RES;
        end else if (poll_last) begin
          state_nxt = S_FIN;
          fail_nxt  = 1'b1;
          to_set    = 1'b1;
        end else begin
          poll_inc = 1'b1;
        end
      end
      S_RD_RES: state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    a_nxt  = ADDR_STAT;
    we_nxt = 1'b0;
    wd_nxt = 4'd0;
    case (state_nxt)
      S_WR_N: begin
        a_nxt  = ADDR_N;
        we_nxt = 1'b1;
        wd_nxt = n_nxt;
      end
      S_WR_GO: begin
        a_nxt  = ADDR_GO;
        we_nxt = 1'b1;
        wd_nxt = 4'b0001;
      end
      S_RD_RES: a_nxt = ADDR_RES;
      default:  a_nxt = ADDR_STAT;
    endcase
    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_FIN);
    done_nxt = (state_nxt == S_FIN) && !fail_nxt;
    err_nxt  = (state_nxt == S_FIN) && fail_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_q      <= 4'd0;
      fail     <= 1'b0;
      wait_cnt <= 1'b0;
      a        <= ADDR_STAT;
      we       <= 1'b0;
      wd       <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      result   <= 32'd0;
    end else begin
      state    <= state_nxt;
      n_q      <= n_nxt;
      fail     <= fail_nxt;
      wait_cnt <= wait_nxt;
      a        <= a_nxt;
      we       <= we_nxt;
      wd       <= wd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      if (state == S_IDLE && start) timeout <= 1'b0;
      else if (to_set)              timeout <= 1'b1;
      if (state == S_RD_RES) result <= rd;
    end
  end

endmodule

// File: tb/tb_fact_seq.sv
// Bench for fact_seq (TIMEOUT=7) with a behavioural accelerator whose status
// appears a programmable number of cycles after the go write.
module tb_fact_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  n_in = 4'd0;
  logic [1:0]  a;
  logic        we;
  logic [3:0]  wd;
  logic [31:0] rd;
  logic        busy, done, err, timeout;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  fact_seq #(.TIMEOUT(7)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .a(a), .we(we),
    .wd(wd), .rd(rd), .busy(busy), .done(done), .err(err),
    .timeout(timeout), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact32(input int n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  // Accelerator: status shows acc_d cycles after go; mode 0 natural,
  // 1 never completes, 2 both status bits set.
  int         acc_cnt = 0;
  logic [3:0] acc_n = 4'd0;
  int         acc_d = 2;
  int         acc_mode = 0;

  always @(posedge clk) begin
    if (we && a == 2'd1) acc_cnt <= 0;
    else if (acc_cnt < 1000) acc_cnt <= acc_cnt + 1;
    if (we && a == 2'd0) acc_n <= wd;
  end

  always_comb begin
    rd = 32'd0;
    if (a == 2'd3) rd = fact32(int'(acc_n));
    else if (a == 2'd2 && acc_cnt >= acc_d) begin
      if (acc_mode == 0)      rd[1:0] = (acc_n >= 4'd13) ? 2'b10 : 2'b01;
      else if (acc_mode == 2) rd[1:0] = 2'b11;
    end
  end

  logic [1:0] wa_q[$];
  logic [3:0] wd_q[$];
  int   stat_cyc = 0, res_cyc = 0, done_cnt = 0, err_cnt = 0, dup_wr = 0;
  logic prev_we = 1'b0;
  logic [1:0] prev_a = 2'd0;

  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(a);
      wd_q.push_back(wd);
      if (prev_we && prev_a == a) dup_wr++;
    end
    prev_we = we;
    prev_a  = a;
    if (busy && a == 2'd2) stat_cyc++;
    if (a == 2'd3) res_cyc++;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  logic [31:0] exp_result = 32'd0;

  task automatic do_txn(input logic [3:0] n, input int d, input int mode,
                        input bit jitter, output int lat, output logic gd,
                        output logic ge, output int polls, output int wr0,
                        output bit hung);
    int s0;
    acc_d = d;
    acc_mode = mode;
    @(negedge clk);
    wr0 = wa_q.size();
    s0 = stat_cyc;
    start = 1'b1;
    n_in = n;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    hung = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (done || err) begin
        hung = 1'b0;
        break;
      end
      if (jitter) begin
        start = 1'($urandom_range(0, 1));
        n_in = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    gd = done;
    ge = err;
    polls = stat_cyc - s0 - 2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses done=%b err=%b want=0,0", done, err); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result got=%0d want=0", result); end
    vectors++; if (we !== 1'b0 || a !== 2'd2 || wd !== 4'd0) begin miscompares++; $display("FAIL reset_bus we=%b a=%0d wd=%0d want=0,2,0", we, a, wd); end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, polls, wr0; logic gd, ge; bit hung;
    do_txn(4'd5, 4, 0, 1'b0, lat, gd, ge, polls, wr0, hung);
    exp_result = 32'd120;
    vectors++; if (hung || gd !== 1'b1 || ge !== 1'b0) begin miscompares++; $display("FAIL basic_outcome done=%b err=%b hung=%0d want=1,0,0", gd, ge, hung); end
    vectors++; if (lat != 8) begin miscompares++; $display("FAIL basic_latency got=%0d want=8", lat); end
    vectors++; if (polls != 3) begin miscompares++; $display("FAIL basic_polls got=%0d want=3", polls); end
    vectors++; if (result !== 32'd120 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_result got=%0d busy=%b want=120,0", result, busy); end
    vectors++;
    if (!(wa_q.size() == wr0 + 2 && wa_q[wr0] == 2'd0 && wd_q[wr0] == 4'd5 &&
          wa_q[wr0+1] == 2'd1 && wd_q[wr0+1] == 4'd1)) begin
      miscompares++; $display("FAIL basic_writes count=%0d want 2 writes (0,5),(1,1)", wa_q.size() - wr0);
    end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_error;
    int lat, polls, wr0; logic gd, ge; bit hung;
    do_txn(4'd13, 3, 0, 1'b0, lat, gd, ge, polls, wr0, hung);
    vectors++; if (hung || gd !== 1'b0 || ge !== 1'b1) begin miscompares++; $display("FAIL err_outcome done=%b err=%b want=0,1", gd, ge); end
    vectors++; if (result !== exp_result) begin miscompares++; $display("FAIL err_result got=%0d want=%0d", result, exp_result); end
    vectors++; if (lat != 4 + 2 || timeout !== 1'b0) begin miscompares++; $display("FAIL err_latency got=%0d to=%b want=6,0", lat, timeout); end
  endtask

  task automatic test_timeout;
    int lat, polls, wr0; logic gd, ge; bit hung;
    do_txn(4'd6, 2, 1, 1'b0, lat, gd, ge, polls, wr0, hung);
    vectors++; if (hung || ge !== 1'b1 || gd !== 1'b0) begin miscompares++; $display("FAIL to_outcome done=%b err=%b want=0,1", gd, ge); end
    vectors++; if (polls != 7 || lat != 11) begin miscompares++; $display("FAIL to_polls polls=%0d lat=%0d want=7,11", polls, lat); end
    @(negedge clk);
    vectors++; if (timeout !== 1'b1 || result !== exp_result) begin miscompares++; $display("FAIL to_sticky to=%b res=%0d want=1,%0d", timeout, result, exp_result); end
    acc_mode = 0;
    acc_d = 2;
    start = 1'b1;
    n_in = 4'd3;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_clear got=%b want=0", timeout); end
    for (int i = 0; i < 50 && !done && !err; i++) @(negedge clk);
    exp_result = 32'd6;
    vectors++; if (done !== 1'b1 || result !== 32'd6) begin miscompares++; $display("FAIL to_recover done=%b res=%0d want=1,6", done, result); end
  endtask

  task automatic test_both_bits;
    int lat, polls, wr0, r0; logic gd, ge; bit hung;
    r0 = res_cyc;
    do_txn(4'd4, 2, 2, 1'b0, lat, gd, ge, polls, wr0, hung);
    vectors++; if (hung || ge !== 1'b1 || gd !== 1'b0) begin miscompares++; $display("FAIL both_outcome done=%b err=%b want=0,1", gd, ge); end
    vectors++; if (res_cyc != r0 || polls != 1 || lat != 5) begin miscompares++; $display("FAIL both_path rdres=%0d polls=%0d lat=%0d want=0,1,5", res_cyc - r0, polls, lat); end
    vectors++; if (result !== exp_result) begin miscompares++; $display("FAIL both_result got=%0d want=%0d", result, exp_result); end
  endtask

  task automatic test_start_held;
    int wr0;
    bit seen;
    acc_mode = 0;
    acc_d = 3;
    @(negedge clk);
    wr0 = wa_q.size();
    start = 1'b1;
    n_in = 4'd7;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || err) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen || wa_q.size() != wr0 + 2) begin miscompares++; $display("FAIL held_single writes=%0d seen=%0d want=2,1", wa_q.size() - wr0, seen); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL held_idle busy=%b want=0", busy); end
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL held_second busy=%b want=1", busy); end
    for (int i = 0; i < 60 && !done && !err; i++) @(negedge clk);
    exp_result = 32'd5040;
    vectors++; if (done !== 1'b1 || result !== 32'd5040 || wa_q.size() != wr0 + 4) begin miscompares++; $display("FAIL held_done done=%b res=%0d writes=%0d want=1,5040,4", done, result, wa_q.size() - wr0); end
  endtask

  task automatic test_reset_mid;
    int wr0, d0, e0;
    acc_mode = 1;
    acc_d = 2;
    @(negedge clk);
    start = 1'b1;
    n_in = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr0 = wa_q.size();
    d0 = done_cnt;
    e0 = err_cnt;
    vectors++; if (busy !== 1'b0 || we !== 1'b0 || a !== 2'd2) begin miscompares++; $display("FAIL rstmid_bus busy=%b we=%b a=%0d want=0,0,2", busy, we, a); end
    vectors++; if (result !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rstmid_out res=%0d done=%b err=%b want=0,0,0", result, done, err); end
    rst = 1'b0;
    exp_result = 32'd0;
    repeat (12) @(negedge clk);
    vectors++; if (wa_q.size() != wr0 || done_cnt != d0 || err_cnt != e0) begin miscompares++; $display("FAIL rstmid_quiet writes=%0d pulses=%0d want=0,0", wa_q.size() - wr0, done_cnt - d0 + err_cnt - e0); end
  endtask

  task automatic test_random;
    int lat, polls, wr0, d, exp_p; logic gd, ge; bit hung, exp_err;
    logic [3:0] n;
    for (int it = 0; it < 16; it++) begin
      n = 4'($urandom_range(0, 14));
      d = $urandom_range(2, 8);
      do_txn(n, d, 0, 1'b1, lat, gd, ge, polls, wr0, hung);
      exp_err = (n >= 4'd13);
      exp_p = d - 1;
      if (!exp_err) exp_result = fact32(int'(n));
      vectors++; if (hung || gd !== !exp_err || ge !== exp_err) begin miscompares++; $display("FAIL rnd_outcome n=%0d done=%b err=%b want_err=%0d", n, gd, ge, exp_err); end
      vectors++; if (result !== exp_result) begin miscompares++; $display("FAIL rnd_result n=%0d got=%0d want=%0d", n, result, exp_result); end
      vectors++; if (polls != exp_p || lat != 4 + exp_p + (exp_err ? 0 : 1)) begin miscompares++; $display("FAIL rnd_timing n=%0d d=%0d polls=%0d lat=%0d want_polls=%0d", n, d, polls, lat, exp_p); end
      vectors++;
      if (!(wa_q.size() == wr0 + 2 && wa_q[wr0] == 2'd0 && wd_q[wr0] == n &&
            wa_q[wr0+1] == 2'd1 && wd_q[wr0+1] == 4'd1)) begin
        miscompares++; $display("FAIL rnd_writes n=%0d count=%0d want=2", n, wa_q.size() - wr0);
      end
    end
    vectors++; if (dup_wr != 0) begin miscompares++; $display("FAIL dup_addr_writes got=%0d want=0", dup_wr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_timeout();
    test_both_bits();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
